countdown_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 4-bit down counter and drives its `IN`, `latch` and `dec` inputs while consuming its `zero` flag. On a start request it captures a load value and a prescale, loads the counter, and issues one `dec` pulse every `prescale+1` cycles until `zero` is seen. It then emits a one-cycle `done` pulse and either stops or reloads for periodic operation. It also counts completed periods and flags start requests that arrive while it is busy.

---
 rtl/countdown_ctrl.sv | 165 ++++++++++++++++
 tb/tb_countdown_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_ctrl
//
// Sequencing controller for a 4-bit down counter. It drives the counter's
// load value (cnt_val), load strobe (latch) and decrement strobe (dec), and
// watches the counter's zero flag. An accepted start request captures a load
// value and a prescale, loads the counter, then issues one dec every
// prescale+1 cycles until zero is seen. Each period ends with a one-cycle
// done pulse. The block then either reloads (periodic mode) or returns to
// idle. Completed periods are counted, and start requests that arrive while
// busy are flagged.
//
// Parameters
//   PRE_W       width of the prescale value and the prescale counter
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   start       start request, only honoured in IDLE
//   load_val    count value captured on an accepted start
//   prescale    decrement spacing captured on an accepted start
//   reload_en   sampled in DONE: 1 = reload and continue, 0 = go idle
//   abort       cancels any operation, highest priority
//   zero        zero flag from the down counter
//   cnt_val     counter load value (the captured load value)
//   latch       counter load strobe
//   dec         counter decrement strobe
//   busy        high whenever the controller is not idle
//   done        one-cycle pulse at the end of each period
//   start_drop  registered pulse: start was seen while not idle
//   periods     completed periods since the last accepted start, saturating
// ---------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       load_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic             reload_en,
  input  logic             abort,
  input  logic             zero,
  output logic [3:0]       cnt_val,
  output logic             latch,
  output logic             dec,
  output logic             busy,
  output logic             done,
  output logic             start_drop,
  output logic [7:0]       periods
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       val_reg, val_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0]       periods_reg, periods_next;
  logic             start_drop_reg, start_drop_next;

  // The prescale counter has reached the captured spacing: this COUNT cycle
  // is a decrement slot.
  logic pre_hit;
  assign pre_hit = (pre_cnt_reg == pre_reg);

  // -------------------------------------------------------------------------
  // State and data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      val_reg        <= '0;
      pre_reg        <= '0;
      pre_cnt_reg    <= '0;
      periods_reg    <= '0;
      start_drop_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      val_reg        <= val_next;
      pre_reg        <= pre_next;
      pre_cnt_reg    <= pre_cnt_next;
      periods_reg    <= periods_next;
      start_drop_reg <= start_drop_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    val_next     = val_reg;
    pre_next     = pre_reg;
    pre_cnt_next = pre_cnt_reg;
    periods_next = periods_reg;

    // A start outside IDLE is a dropped request, independent of abort.
    start_drop_next = start && (state_reg != S_IDLE);

    if (abort) begin
      // Abort wins over everything; captured values and the period count
      // are left untouched.
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            val_next     = load_val;
            pre_next     = prescale;
            periods_next = '0;
            state_next   = S_LOAD;
          end
        end

        S_LOAD: begin
          pre_cnt_next = '0;
          state_next   = S_COUNT;
        end

        S_COUNT: begin
          if (zero) begin
            state_next = S_DONE;
          end else if (pre_hit) begin
            pre_cnt_next = '0;
          end else begin
            pre_cnt_next = pre_cnt_reg + PRE_W'(1);
          end
        end

        S_DONE: begin
          if (periods_reg != 8'hFF) begin
            periods_next = periods_reg + 8'd1;
          end
          // Reload re-enters LOAD with the same captured values.
          state_next = reload_en ? S_LOAD : S_IDLE;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    latch = (state_reg == S_LOAD) && !abort;
    dec   = (state_reg == S_COUNT) && !zero && pre_hit && !abort;
    done  = (state_reg == S_DONE) && !abort;
    busy  = (state_reg != S_IDLE);
  end

  assign cnt_val    = val_reg;
  assign periods    = periods_reg;
  assign start_drop = start_drop_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for countdown_ctrl. A small model of the 4-bit down counter
// closes the loop on zero. Expected waveforms are derived from the period
// timing rules (latch, dec and done cycles computed arithmetically from the
// load value, prescale and number of periods).
// ---------------------------------------------------------------------------
module tb_countdown_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] load_val;
  logic [7:0] prescale;
  logic       reload_en;
  logic       abort;
  logic       zero;
  logic [3:0] cnt_val;
  logic       latch;
  logic       dec;
  logic       busy;
  logic       done;
  logic       start_drop;
  logic [7:0] periods;

  int total = 0;
  int bad   = 0;

  int obs_first_done;
  int obs_ndec;
  int obs_last_periods;

  countdown_ctrl #(.PRE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_val   (load_val),
    .prescale   (prescale),
    .reload_en  (reload_en),
    .abort      (abort),
    .zero       (zero),
    .cnt_val    (cnt_val),
    .latch      (latch),
    .dec        (dec),
    .busy       (busy),
    .done       (done),
    .start_drop (start_drop),
    .periods    (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Down counter being controlled.
  logic [3:0] cnt_m;
  always @(posedge clk) begin
    if (!rst_n)     cnt_m <= 4'd0;
    else if (latch) cnt_m <= cnt_val;
    else if (dec)   cnt_m <= cnt_m - 4'd1;
  end
  assign zero = (cnt_m == 4'd0);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs r periods of load value n / prescale p starting with a start request
  // in cycle 0, comparing every cycle against the timing rules. reload_en is
  // held high until the final done cycle. The window ends tail cycles after
  // the last done; tail=0 makes the next run's start land on the first
  // possible cycle.
  task automatic run_window(input int n, input int p, input int r, input int tail);
    bit latch_set[int];
    bit dec_set[int];
    bit done_set[int];
    int s, d, len, exp_per;
    s = 0;
    d = 0;
    for (int i = 0; i < r; i++) begin
      latch_set[s + 1] = 1'b1;
      for (int k = 1; k <= n; k++) dec_set[s + 1 + k * (p + 1)] = 1'b1;
      d = s + 3 + n * (p + 1);
      done_set[d] = 1'b1;
      s = d;
    end
    len = d + 1 + tail;
    exp_per = 0;
    obs_first_done = -1;
    obs_ndec = 0;
    obs_last_periods = -1;
    for (int c = 0; c < len; c++) begin
      start     = (c == 0);
      load_val  = 4'(n);
      prescale  = 8'(p);
      reload_en = (c < d);
      abort     = 1'b0;
      #1;
      if (c >= 1 && done_set.exists(c - 1) && exp_per < 255) exp_per++;
      chk("latch", int'(latch), int'(latch_set.exists(c)));
      chk("dec", int'(dec), int'(dec_set.exists(c)));
      chk("done", int'(done), int'(done_set.exists(c)));
      chk("busy", int'(busy), int'(c >= 1 && c <= d));
      chk("start_drop", int'(start_drop), 0);
      if (c >= 1) begin
        chk("periods", int'(periods), exp_per);
        chk("cnt_val", int'(cnt_val), n);
      end
      if (done && obs_first_done < 0) obs_first_done = c;
      if (dec) obs_ndec++;
      obs_last_periods = int'(periods);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    $display("run n=%0d p=%0d periods=%0d cycles=%0d first_done=%0d decs=%0d",
             n, p, r, len, obs_first_done, obs_ndec);
  endtask

  typedef struct {
    int n;
    int p;
    int r;
    int exp_done1;
    int exp_ndec;
    int exp_periods;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{n: 3, p: 0, r: 1,   exp_done1: 6, exp_ndec: 3, exp_periods: 1};
    vecs[1] = '{n: 2, p: 2, r: 1,   exp_done1: 9, exp_ndec: 2, exp_periods: 1};
    vecs[2] = '{n: 0, p: 5, r: 1,   exp_done1: 3, exp_ndec: 0, exp_periods: 1};
    vecs[3] = '{n: 3, p: 0, r: 3,   exp_done1: 6, exp_ndec: 9, exp_periods: 3};
    vecs[4] = '{n: 0, p: 0, r: 257, exp_done1: 3, exp_ndec: 0, exp_periods: 255};

    rst_n = 1'b0;
    start = 1'b0;
    load_val = 4'd0;
    prescale = 8'd0;
    reload_en = 1'b0;
    abort = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state.
    chk("rst_busy", int'(busy), 0);
    chk("rst_latch", int'(latch), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_start_drop", int'(start_drop), 0);
    chk("rst_cnt_val", int'(cnt_val), 0);
    chk("rst_periods", int'(periods), 0);
    $display("reset state checked");

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; load_val = 4'd7; prescale = 8'd3;
    step();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_cnt_val", int'(cnt_val), 0);
    chk("abort_start_drop", int'(start_drop), 0);
    step();
    $display("start with abort in idle checked");

    // Table-driven scenarios.
    for (int i = 0; i < 5; i++) begin
      run_window(vecs[i].n, vecs[i].p, vecs[i].r, 1);
      chk("tbl_first_done", obs_first_done, vecs[i].exp_done1);
      chk("tbl_ndec", obs_ndec, vecs[i].exp_ndec);
      chk("tbl_periods", obs_last_periods, vecs[i].exp_periods);
    end

    // Busy start then abort on the second dec slot of the second period.
    // n=2 p=1 reload: latch 1, dec 3,5, done 7, latch 8, dec slots 10,12.
    for (int c = 0; c < 15; c++) begin
      start     = (c == 0) || (c == 10);
      load_val  = (c == 10) ? 4'd9 : 4'd2;
      prescale  = 8'd1;
      reload_en = 1'b1;
      abort     = (c == 12);
      #1;
      if (c == 1 || c == 8) chk("ab_latch", int'(latch), 1);
      if (c == 3 || c == 5 || c == 10) chk("ab_dec", int'(dec), 1);
      if (c == 7) chk("ab_done", int'(done), 1);
      if (c == 11) begin
        chk("ab_start_drop", int'(start_drop), 1);
        chk("ab_no_recapture", int'(cnt_val), 2);
      end
      if (c == 12) begin
        chk("ab_dec_suppressed", int'(dec), 0);
        chk("ab_busy_in_abort", int'(busy), 1);
      end
      if (c == 13) begin
        chk("ab_idle", int'(busy), 0);
        chk("ab_periods_held", int'(periods), 1);
        chk("ab_cnt_val_held", int'(cnt_val), 2);
        chk("ab_start_drop_once", int'(start_drop), 0);
      end
      if (c >= 12) begin
        chk("ab_no_done", int'(done), 0);
        chk("ab_no_latch", int'(latch), 0);
      end
      step();
    end
    abort = 1'b0;
    reload_en = 1'b0;
    $display("busy start and abort sequence checked");

    // Reset during COUNT, with a busy start in the same cycle.
    for (int c = 0; c < 5; c++) begin
      start    = (c == 0) || (c == 4);
      load_val = 4'd3;
      prescale = 8'd2;
      rst_n    = (c != 4);
      step();
    end
    start = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_latch", int'(latch), 0);
    chk("mrst_dec", int'(dec), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_start_drop", int'(start_drop), 0);
    chk("mrst_cnt_val", int'(cnt_val), 0);
    chk("mrst_periods", int'(periods), 0);
    step();
    $display("reset during count checked");
    run_window(3, 0, 1, 1);
    chk("post_rst_first_done", obs_first_done, 6);
    chk("post_rst_ndec", obs_ndec, 3);

    // Randomized runs, some back to back.
    for (int i = 0; i < 24; i++) begin
      run_window(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                 int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
